tohost_monitor: RTL

TOHOST_MONITOR -- requirements
Module: tohost_monitor

---
 rtl/tohost_pkg.sv | 9 +
 rtl/tohost_fifo.sv | 48 ++++
 rtl/tohost_monitor.sv | 80 ++++++++
 3 files changed

// File: rtl/tohost_pkg.sv
// tohost_pkg: shared FSM state encoding and the pass code for the tohost monitor
package tohost_pkg;
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;
    localparam logic [31:0] PASS_CODE = 32'h1;
endpackage

// File: rtl/tohost_fifo.sv
// tohost_fifo: first-word-fall-through message FIFO with occupancy count
module tohost_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;
    // Pointer and count updates; pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        full     = cnt_q == CW'(DEPTH);
        empty    = cnt_q == '0;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
        dout     = mem_q[rd_ptr_q];
        count    = cnt_q;
    end
    // Storage and pointer registers; reset empties the queue at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (do_push) mem_q[wr_ptr_q] <= din;
        end
    end
endmodule

// File: rtl/tohost_monitor.sv
// tohost_monitor: queues tohost writes for the host and reports test termination status
module tohost_monitor
    import tohost_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             csrw_valid,
    input  logic [31:0]      csrw_data,
    output logic             stall_req,
    output logic             host_valid,
    output logic [31:0]      host_data,
    input  logic             host_ready,
    output logic             done,
    output logic             pass,
    output logic [30:0]      fail_test,
    output logic [CNT_W-1:0] write_count
);
    state_t                  state_q, state_d;
    logic [31:0]             term_q, term_d;
    logic [CNT_W-1:0]        wc_q, wc_d;
    logic                    push, pop, full, empty;
    logic [$clog2(DEPTH):0]  fifo_count;

    tohost_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (csrw_data),
        .dout  (host_data),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // Handshakes: writes are only taken in RUN with room; full blocks push even when popping
    always_comb begin
        push       = csrw_valid && state_q == RUN && !full;
        pop        = host_ready && !empty;
        stall_req  = full;
        host_valid = !empty;
        term_d     = (push && csrw_data[0]) ? csrw_data : term_q;
        wc_d       = (push && wc_q != '1) ? wc_q + CNT_W'(1) : wc_q;
    end

    // Next state: terminal write starts the drain, an empty queue in drain finishes
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     state_d = (push && csrw_data[0]) ? DRAIN : RUN;
            DRAIN:   state_d = (fifo_count == '0) ? DONE : DRAIN;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    // Status outputs derive only from registered state and the captured terminal value
    always_comb begin
        done        = state_q == DONE;
        pass        = state_q == DONE && term_q == PASS_CODE;
        fail_test   = (state_q == DONE && term_q != PASS_CODE) ? term_q[31:1] : '0;
        write_count = wc_q;
    end

    // State, terminal capture and saturating write counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            term_q  <= '0;
            wc_q    <= '0;
        end else begin
            state_q <= state_d;
            term_q  <= term_d;
            wc_q    <= wc_d;
        end
    end
endmodule
